router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-reception controller for the 1x3 router. It sequences the input register block and the synchronizer through header decode, payload load, FIFO-full stall, parity load and parity check.
- Its outputs are the control strobes (detect_add, write_enb_reg, ld/lfd/laf/full state flags, rst_int_reg), and it drives busy back to the packet source.
- It is a pure Moore controller with one registered state plus one latched destination address.

Parameters:
- NUM_PORTS, 3, number of output FIFOs. A destination is valid only if it is less than NUM_PORTS.
- ADDR_W, 2, width of the destination field in data_in.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces DECODE_ADDRESS.
- pkt_valid  input  1  source has a valid byte this cycle; falls after the last payload byte.
- data_in  input  ADDR_W  destination field of the header byte; sampled in DECODE_ADDRESS.
- fifo_full  input  1  selected FIFO full (from synchronizer).
- fifo_empty  input  NUM_PORTS  per-FIFO empty flags.
- soft_reset  input  NUM_PORTS  per-FIFO timeout soft reset (from synchronizer).
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  register block saw pkt_valid fall while stalled.
- detect_add  output  1  high in DECODE_ADDRESS.
- lfd_state  output  1  high in LOAD_FIRST_DATA.
- ld_state  output  1  high in LOAD_DATA.
- laf_state  output  1  high in LOAD_AFTER_FULL.
- full_state  output  1  high in FIFO_FULL_STATE.
- write_enb_reg  output  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR.
- busy  output  1  high in every state except DECODE_ADDRESS and LOAD_DATA.

Behaviour:
- States: DECODE_ADDRESS (reset state), LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Outputs are decoded combinationally from the state register only; there are no Mealy paths. Each state change takes effect one clock after the causing input.
- Reset values: state=DECODE_ADDRESS, addr_q=0, detect_add=1, all other outputs 0.
- addr_q latches data_in on the clock edge where state==DECODE_ADDRESS and pkt_valid=1 and data_in<NUM_PORTS. It holds for the rest of the packet.
- Transitions, priority order:
  1. reset (async).
  2. soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS.
  3. Normal transitions below.
- DECODE_ADDRESS:
  - pkt_valid & valid addr & fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid & valid addr & !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - pkt_valid with data_in>=NUM_PORTS -> stay; the packet is dropped.
  - otherwise stay.
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally. Header is written in exactly one cycle.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full wins when it coincides with pkt_valid falling.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay, indefinitely.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Unreachable state encodings recover to DECODE_ADDRESS on the next clock.
- Reset asserted mid-packet: outputs go to reset values immediately, without waiting for clk.

Decomposition:
- Shared package router_pkg holds:
  - state enumeration (3-bit encoding);
  - ADDR_W and NUM_PORTS defaults;
  - ADDR_INVALID constant = 2'b11.
- The synchronizer and register blocks import the same package.
- No sub-module; the next-state logic, addr_q register and output decode live in one module.

Test Plan:
- Reset with fifo_empty=3'b111, then pkt_valid=1 with data_in=2'b01 -> LOAD_FIRST_DATA next cycle (lfd_state=1, busy=1), then LOAD_DATA (ld_state=1, write_enb_reg=1, busy=0).
- In LOAD_DATA drop pkt_valid -> LOAD_PARITY (write_enb_reg=1, busy=1), then CHECK_PARITY_ERROR (rst_int_reg=1), then DECODE_ADDRESS (detect_add=1).
- In LOAD_DATA raise fifo_full for 5 cycles -> full_state=1 for 5 cycles; then fifo_full=0 with low_pkt_valid=1 -> LOAD_AFTER_FULL, then LOAD_PARITY.
- data_in=2'b10 with fifo_empty[2]=0 -> WAIT_TILL_EMPTY with busy=1 held; set fifo_empty[2]=1 -> LOAD_FIRST_DATA next cycle.
- data_in=2'b11 with pkt_valid=1 -> remains DECODE_ADDRESS, busy=0, write_enb_reg=0.
- In FIFO_FULL_STATE with addr_q=0, pulse soft_reset[0] -> DECODE_ADDRESS next cycle. Separately, assert reset mid-LOAD_DATA -> detect_add=1 immediately and all other outputs 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and defaults for the 1x3 router blocks.
package router_pkg;

  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_ADDR_W    = 2;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router.
// Moore FSM with a latched destination address.
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 busy
);

  localparam logic [ADDR_W:0] NP_W = (ADDR_W+1)'(NUM_PORTS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_PORTS-1:0] sr_sel, fe_din_sel, fe_addr_sel;
  logic                addr_ok;

  // Shift-based selects keep out-of-range indices harmless.
  assign sr_sel      = soft_reset >> addr_q;
  assign fe_din_sel  = fifo_empty >> data_in;
  assign fe_addr_sel = fifo_empty >> addr_q;
  assign addr_ok     = {1'b0, data_in} < NP_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && addr_ok) begin
          addr_d  = data_in;
          state_d = fe_din_sel[0] ? LOAD_FIRST_DATA
                                  : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:
        if (fe_addr_sel[0]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:
        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        state_d = DECODE_ADDRESS;
    endcase
    if (state_q != DECODE_ADDRESS && sr_sel[0])
      state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, async reset
// check, and random traffic against a behavioural model.
module tb_router_fsm;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic detect_add, lfd_state, ld_state, laf_state;
  logic full_state, write_enb_reg, rst_int_reg, busy;

  router_fsm dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [7:0] outs = {detect_add, lfd_state, ld_state, laf_state,
                     full_state, write_enb_reg, rst_int_reg, busy};

  // Expected output bundles per controller phase
  localparam logic [7:0] O_DEC  = 8'h80;
  localparam logic [7:0] O_LFD  = 8'h41;
  localparam logic [7:0] O_LD   = 8'h24;
  localparam logic [7:0] O_LAF  = 8'h15;
  localparam logic [7:0] O_FULL = 8'h09;
  localparam logic [7:0] O_LP   = 8'h05;
  localparam logic [7:0] O_CPE  = 8'h03;
  localparam logic [7:0] O_WTE  = 8'h01;

  typedef struct packed {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_pass = 0;

  function automatic vec_t mk(logic pv, logic [1:0] din, logic ff,
                              logic [2:0] fe, logic [2:0] sr,
                              logic pd, logic lpv, logic [7:0] e);
    vec_t v;
    v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] e);
    n_chk++;
    if (got === e) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, got, e);
  endtask

  task automatic drive(logic pv, logic [1:0] din, logic ff,
                       logic [2:0] fe, logic [2:0] sr,
                       logic pd, logic lpv);
    pkt_valid = pv; data_in = din; fifo_full = ff;
    fifo_empty = fe; soft_reset = sr;
    parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phase names as strings, own transition rules
  string m_ph;
  int    m_addr;

  function automatic logic [7:0] m_out(string ph);
    case (ph)
      "dec":  return O_DEC;
      "lfd":  return O_LFD;
      "ld":   return O_LD;
      "laf":  return O_LAF;
      "full": return O_FULL;
      "lp":   return O_LP;
      "cpe":  return O_CPE;
      default: return O_WTE;
    endcase
  endfunction

  task automatic m_step();
    string nx;
    nx = m_ph;
    if (m_ph == "dec") begin
      if (pkt_valid && int'(data_in) < 3) begin
        m_addr = int'(data_in);
        nx = fifo_empty[data_in] ? "lfd" : "wte";
      end
    end else if (m_ph == "wte") begin
      if (fifo_empty[m_addr]) nx = "lfd";
    end else if (m_ph == "lfd") nx = "ld";
    else if (m_ph == "ld") begin
      if (fifo_full) nx = "full";
      else if (!pkt_valid) nx = "lp";
    end else if (m_ph == "full") begin
      if (!fifo_full) nx = "laf";
    end else if (m_ph == "laf") begin
      nx = parity_done ? "dec" : (low_pkt_valid ? "lp" : "ld");
    end else if (m_ph == "lp") nx = "cpe";
    else if (m_ph == "cpe") nx = fifo_full ? "full" : "dec";
    if (m_ph != "dec" && soft_reset[m_addr]) nx = "dec";
    m_ph = nx;
  endtask

  initial begin
    logic [1:0] bad;
    bad = ADDR_INVALID;
    reset = 1'b1;
    drive(0, 0, 0, 3'b111, 0, 0, 0);
    #2;
    check("reset_state", outs, O_DEC);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_after_reset", outs, O_DEC);

    // Header, payload, parity, check
    tbl.push_back(mk(1, 1,   0, 3'b111, 0, 0, 0, O_LFD));
    tbl.push_back(mk(1, 1,   0, 3'b111, 0, 0, 0, O_LD));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 0, O_LP));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 0, O_CPE));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 0, O_DEC));
    // FIFO full stall for five cycles, then low_pkt_valid
    tbl.push_back(mk(1, 1,   0, 3'b111, 0, 0, 0, O_LFD));
    tbl.push_back(mk(1, 1,   0, 3'b111, 0, 0, 0, O_LD));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 1, 3'b111, 0, 0, 0, O_FULL));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 1, O_LAF));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 1, O_LP));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 0, O_CPE));
    tbl.push_back(mk(0, 1,   0, 3'b111, 0, 0, 0, O_DEC));
    // Destination busy: wait for FIFO 2 to drain
    tbl.push_back(mk(1, 2,   0, 3'b011, 0, 0, 0, O_WTE));
    tbl.push_back(mk(0, 2,   0, 3'b011, 0, 0, 0, O_WTE));
    tbl.push_back(mk(1, 2,   0, 3'b111, 0, 0, 0, O_LFD));
    tbl.push_back(mk(1, 2,   0, 3'b111, 0, 0, 0, O_LD));
    tbl.push_back(mk(0, 2,   1, 3'b111, 0, 0, 0, O_FULL));
    tbl.push_back(mk(0, 2,   0, 3'b111, 0, 0, 0, O_LAF));
    tbl.push_back(mk(1, 2,   0, 3'b111, 0, 0, 0, O_LD));
    tbl.push_back(mk(0, 2,   0, 3'b111, 0, 0, 0, O_LP));
    tbl.push_back(mk(0, 2,   1, 3'b111, 0, 0, 0, O_CPE));
    tbl.push_back(mk(0, 2,   1, 3'b111, 0, 0, 0, O_FULL));
    tbl.push_back(mk(0, 2,   0, 3'b111, 0, 1, 0, O_LAF));
    tbl.push_back(mk(0, 2,   0, 3'b111, 0, 1, 0, O_DEC));
    // Invalid destination is dropped
    tbl.push_back(mk(1, bad, 0, 3'b111, 0, 0, 0, O_DEC));
    tbl.push_back(mk(1, bad, 0, 3'b111, 0, 0, 0, O_DEC));
    // Soft reset only for the latched port
    tbl.push_back(mk(1, 0,   0, 3'b111, 0, 0, 0, O_LFD));
    tbl.push_back(mk(1, 0,   0, 3'b111, 0, 0, 0, O_LD));
    tbl.push_back(mk(1, 0,   1, 3'b111, 0, 0, 0, O_FULL));
    tbl.push_back(mk(1, 0,   1, 3'b111, 3'b010, 0, 0, O_FULL));
    tbl.push_back(mk(1, 0,   1, 3'b111, 3'b001, 0, 0, O_DEC));
    tbl.push_back(mk(0, 0,   0, 3'b111, 0, 0, 0, O_DEC));

    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].din, tbl[i].ff, tbl[i].fe,
            tbl[i].sr, tbl[i].pd, tbl[i].lpv);
      tick();
      check($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    // Async reset in the middle of LOAD_DATA
    drive(1, 1, 0, 3'b111, 0, 0, 0);
    tick();
    tick();
    check("pre_reset_ld", outs, O_LD);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_now", outs, O_DEC);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    check("after_async_reset", outs, O_DEC);

    // Random traffic against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ph = "dec";
    m_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0,
            3'($urandom),
            ($urandom_range(0, 15) == 0) ?
              3'(1 << $urandom_range(0, 2)) : 3'b000,
            $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)));
      m_step();
      tick();
      check($sformatf("rand%0d_%s", c, m_ph), outs, m_out(m_ph));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
